// File: rtl/pc_pkg.sv
// Shared definitions for the PC generator: default vectors, redirect FSM
// states and the next-PC select encoding.
package pc_pkg;

   localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_3000;
   localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_4180;

   typedef enum logic {
      RUN        = 1'b0,
      HOLD_REDIR = 1'b1
   } redir_state_e;

   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_BR   = 3'd1,
      SEL_PEND = 3'd2,
      SEL_HOLD = 3'd3,
      SEL_ERET = 3'd4,
      SEL_EXC  = 3'd5
   } pc_sel_e;

   // Fixed priority: exception > eret > stall > buffered redirect > branch > sequential.
   function automatic pc_sel_e pc_select(input logic exc_req,
                                         input logic eret,
                                         input logic stall,
                                         input logic pend,
                                         input logic br_valid);
      pc_sel_e sel;
      if (exc_req)       sel = SEL_EXC;
      else if (eret)     sel = SEL_ERET;
      else if (stall)    sel = SEL_HOLD;
      else if (pend)     sel = SEL_PEND;
      else if (br_valid) sel = SEL_BR;
      else               sel = SEL_SEQ;
      return sel;
   endfunction

endpackage

// File: rtl/pc_redir_buf.sv
// Buffers a redirect that arrives while the PC is stalled so it can be
// applied on the first unstalled cycle.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   RUN        | no redirect buffered; branches go straight to the PC
//   HOLD_REDIR | stalled with a redirect held in pend_target
module pc_redir_buf
   import pc_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              flush,
   output logic              pend,
   output logic [ADDR_W-1:0] pend_target
);

   redir_state_e state, state_nxt;
   logic         capture;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= RUN;
         pend_target <= '0;
      end else begin
         state <= state_nxt;
         if (capture) pend_target <= br_target;
      end
   end

   // Exception entry/return flushes the buffer; a later branch while
   // still stalled simply overwrites the held target.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      if (flush) begin
         state_nxt = RUN;
      end else begin
         case (state)
            RUN: begin
               if (stall && br_valid) begin
                  capture   = 1'b1;
                  state_nxt = HOLD_REDIR;
               end
            end
            HOLD_REDIR: begin
               if (stall) capture   = br_valid;
               else       state_nxt = RUN;
            end
         endcase
      end
   end

   assign pend = (state == HOLD_REDIR);

endmodule

// File: rtl/pc_gen.sv
// Program counter generator with stall, buffered redirect and exception entry/return.
// Optional PC window/alignment checking is enabled by defining PC_FAULT_CHECK_EN.
module pc_gen
   import pc_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                IDX_W     = 12,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              exc_req,
   input  logic              eret,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [IDX_W-1:0]  imem_idx,
   output logic [ADDR_W-1:0] epc,
   output logic              pend,
   output logic              fault
);

   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] pend_target;
   logic              idx_borrow;
   pc_sel_e           sel;

   pc_redir_buf #(
      .ADDR_W (ADDR_W)
   ) u_redir_buf (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .flush       (exc_req | eret),
      .pend        (pend),
      .pend_target (pend_target)
   );

   assign sel = pc_select(exc_req, eret, stall, pend, br_valid);

   always_comb begin
      pc_nxt = pc_plus4;
      case (sel)
         SEL_EXC:  pc_nxt = EXC_VEC;
         SEL_ERET: pc_nxt = epc;
         SEL_HOLD: pc_nxt = pc;
         SEL_PEND: pc_nxt = pend_target;
         SEL_BR:   pc_nxt = br_target;
         default:  pc_nxt = pc_plus4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc  <= RESET_VEC;
         epc <= '0;
      end else begin
         pc <= pc_nxt;
         if (exc_req) epc <= pc;
      end
   end

   assign pc_plus4 = pc + ADDR_W'(4);

   // Word index of (pc - RESET_VEC): subtract only the index field and fold in
   // the borrow from the byte-offset bits.
   assign idx_borrow = (pc[1:0] < RESET_VEC[1:0]);
   assign imem_idx   = pc[IDX_W+1:2] - RESET_VEC[IDX_W+1:2] - IDX_W'(idx_borrow);

`ifdef PC_FAULT_CHECK_EN
   localparam logic [ADDR_W:0] IMEM_END =
      {1'b0, RESET_VEC} + ((ADDR_W+1)'(1) << (IDX_W + 2));

   assign fault = (pc[1:0] != 2'b00) ||
                  (pc < RESET_VEC)   ||
                  ({1'b0, pc} >= IMEM_END);
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: behavioural model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_pc_gen;

`ifdef PC_FAULT_CHECK_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        br_valid = 1'b0;
   logic [31:0] br_target = '0;
   logic        exc_req = 1'b0;
   logic        eret = 1'b0;
   logic [31:0] pc, pc_plus4, epc;
   logic [11:0] imem_idx;
   logic        pend, fault;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] m_pc, m_epc, m_tgt;
   bit          m_pend;
   bit          chk_on = 1'b0;
   bit          watch = 1'b0;
   bit          seen_3300 = 1'b0;

   pc_gen dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .br_valid  (br_valid),
      .br_target (br_target),
      .exc_req   (exc_req),
      .eret      (eret),
      .pc        (pc),
      .pc_plus4  (pc_plus4),
      .imem_idx  (imem_idx),
      .epc       (epc),
      .pend      (pend),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_idx(input logic [31:0] p);
      return ((p - 32'h3000) >> 2) & 32'hFFF;
   endfunction

   function automatic logic [31:0] m_fault(input logic [31:0] p);
      bit f;
      f = (p % 4 != 0) || (p < 32'h3000) || (p >= 32'h3000 + 4 * 4096);
      return {31'b0, FAULT_EN && f};
   endfunction

   // Architectural effect of one clock edge given the inputs present.
   task automatic model_step();
      if (!reset) begin
         m_pc = 32'h3000; m_epc = '0; m_pend = 1'b0; m_tgt = '0;
      end else if (exc_req) begin
         m_epc = m_pc; m_pc = 32'h4180; m_pend = 1'b0;
      end else if (eret) begin
         m_pc = m_epc; m_pend = 1'b0;
      end else if (stall) begin
         if (br_valid) begin m_pend = 1'b1; m_tgt = br_target; end
      end else if (m_pend) begin
         m_pc = m_tgt; m_pend = 1'b0;
      end else if (br_valid) begin
         m_pc = br_target;
      end else begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("pc",       pc,                m_pc);
         chk("pc_plus4", pc_plus4,          m_pc + 32'd4);
         chk("imem_idx", {20'b0, imem_idx}, m_idx(m_pc));
         chk("epc",      epc,               m_epc);
         chk("pend",     {31'b0, pend},     {31'b0, m_pend});
         chk("fault",    {31'b0, fault},    m_fault(m_pc));
         if (watch && pc == 32'h3300) seen_3300 = 1'b1;
      end
   end

   task automatic step(input bit rst_n, input bit st, input bit bv, input logic [31:0] bt,
                       input bit ex, input bit er);
      @(negedge clk);
      reset = rst_n; stall = st; br_valid = bv; br_target = bt; exc_req = ex; eret = er;
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic run_free(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 32'h0, 0, 0);
   endtask

   initial begin
      // reset held two cycles
      step(0, 0, 0, 32'h0, 0, 0);
      chk_on = 1'b1;
      step(0, 1, 1, 32'h5555, 1, 1);
      chk("lit_rst_pc",    pc,                32'h3000);
      chk("lit_rst_idx",   {20'b0, imem_idx}, 32'h0);
      chk("lit_rst_plus4", pc_plus4,          32'h3004);
      chk("lit_rst_pend",  {31'b0, pend},     32'h0);
      chk("lit_rst_epc",   epc,               32'h0);
      chk("lit_rst_fault", {31'b0, fault},    32'h0);

      // sequential fetch then redirect
      run_free(3);
      chk("lit_seq_pc", pc, 32'h300C);
      step(1, 0, 1, 32'h3100, 0, 0);
      chk("lit_br_pc",  pc,                32'h3100);
      chk("lit_br_idx", {20'b0, imem_idx}, 32'h40);

      // redirect captured during stall
      step(1, 1, 1, 32'h3200, 0, 0);
      chk("lit_hold_pend", {31'b0, pend}, 32'h1);
      chk("lit_hold_pc",   pc,            32'h3100);
      step(1, 1, 0, 32'h0, 0, 0);
      step(1, 1, 0, 32'h0, 0, 0);
      chk("lit_hold3_pend", {31'b0, pend}, 32'h1);
      chk("lit_hold3_pc",   pc,            32'h3100);
      step(1, 0, 0, 32'h0, 0, 0);
      chk("lit_rel_pc",   pc,            32'h3200);
      chk("lit_rel_pend", {31'b0, pend}, 32'h0);

      // overwrite while held; same-cycle branch on release is ignored
      step(1, 1, 1, 32'h3240, 0, 0);
      step(1, 1, 1, 32'h3280, 0, 0);
      step(1, 0, 1, 32'h3999, 0, 0);
      chk("lit_ovw_pc", pc, 32'h3280);
      run_free(1);

      // exception entry with stall asserted, then return
      step(0, 0, 0, 32'h0, 0, 0);
      run_free(2);
      chk("lit_pre_exc_pc", pc, 32'h3008);
      step(1, 1, 0, 32'h0, 1, 0);
      chk("lit_exc_pc",  pc,  32'h4180);
      chk("lit_exc_epc", epc, 32'h3008);
      run_free(2);
      step(1, 1, 0, 32'h0, 0, 1);
      chk("lit_eret_pc",  pc,  32'h3008);
      chk("lit_eret_epc", epc, 32'h3008);

      // exception cancels a pending redirect
      step(1, 1, 1, 32'h3300, 0, 0);
      chk("lit_pend3300", {31'b0, pend}, 32'h1);
      watch = 1'b1;
      step(1, 1, 0, 32'h0, 1, 0);
      chk("lit_cancel_pc",   pc,            32'h4180);
      chk("lit_cancel_pend", {31'b0, pend}, 32'h0);
      run_free(3);
      chk("lit_never_3300", {31'b0, seen_3300}, 32'h0);
      watch = 1'b0;

      // reset while holding discards the redirect
      step(1, 1, 1, 32'h3500, 0, 0);
      step(0, 1, 0, 32'h0, 0, 0);
      chk("lit_rsthold_pend", {31'b0, pend}, 32'h0);
      chk("lit_rsthold_pc",   pc,            32'h3000);
      step(1, 0, 0, 32'h0, 0, 0);
      chk("lit_rsthold_next", pc, 32'h3004);

      // fault window and wrap-around
      step(1, 0, 1, 32'h3002, 0, 0);
      chk("lit_fault_misal", {31'b0, fault}, {31'b0, FAULT_EN});
      step(1, 0, 1, 32'h7000, 0, 0);
      chk("lit_fault_high", {31'b0, fault}, {31'b0, FAULT_EN});
      step(1, 0, 1, 32'h6FFC, 0, 0);
      chk("lit_fault_last", {31'b0, fault}, 32'h0);
      step(1, 0, 1, 32'h2FFC, 0, 0);
      chk("lit_fault_low", {31'b0, fault}, {31'b0, FAULT_EN});
      step(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
      chk("lit_wrap_plus4", pc_plus4,          32'h0);
      chk("lit_wrap_idx",   {20'b0, imem_idx}, 32'h3FF);
      run_free(1);
      chk("lit_wrap_pc",  pc,                32'h0);
      chk("lit_wrap_idx0", {20'b0, imem_idx}, 32'h400);

      @(negedge clk);
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
